// File: rtl/mem_line_responder_pkg.sv
// Shared FSM state type, line geometry constants and sizing helper for the
// memory line responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    localparam int unsigned OFFSET_BITS    = 4;
    localparam int unsigned WORDS_PER_LINE = 4;

    function automatic int unsigned line_bits(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// Refill/update bus between the cache controller (master) and the memory
// responder (slave). MEM_WSTRB_EN adds the per-byte write strobe.
interface mem_line_responder_if
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DATA_WIDTH_MEM = 128
);

    logic                      mem_req;
    logic                      mem_we;
    logic [WIDTH-1:0]          mem_addr;
    logic [WIDTH-1:0]          mem_wdata;
`ifdef MEM_WSTRB_EN
    logic [3:0]                mem_wstrb;
`endif
    logic                      mem_ready;
    logic                      mem_ack;
    logic [DATA_WIDTH_MEM-1:0] mem_rdata;

    modport master (
`ifdef MEM_WSTRB_EN
        output mem_wstrb,
`endif
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
`ifdef MEM_WSTRB_EN
        input  mem_wstrb,
`endif
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_line_responder_ram.sv
// Single-port line RAM: per-lane write enable, registered read that holds
// its output until the next read enable. Contents are not reset.
module mem_line_ram
    import mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH      = 256,
    parameter int unsigned DATA_WIDTH_MEM = 128,
    parameter int unsigned LANES          = WORDS_PER_LINE,
    parameter int unsigned ADDR_BITS      = line_bits(MEM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_BITS-1:0]      i_addr,
    input  logic [LANES-1:0]          i_we,
    input  logic [DATA_WIDTH_MEM-1:0] i_wdata,
    input  logic                      i_re,
    output logic [DATA_WIDTH_MEM-1:0] o_rdata
);

    localparam int unsigned LANE_W = DATA_WIDTH_MEM / LANES;

    logic [DATA_WIDTH_MEM-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (i_we[l]) begin
                r_mem[i_addr][l*LANE_W +: LANE_W] <= i_wdata[l*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency memory responder: single outstanding word write / line read.
// MEM_WSTRB_EN enables byte-strobed writes.
module mem_line_responder
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned DATA_WIDTH_MEM = 128,
    parameter int unsigned MEM_DEPTH      = 256,
    parameter int unsigned LATENCY        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_line_responder_if.slave  bus
);

    localparam int unsigned LINE_BITS = line_bits(MEM_DEPTH);
`ifdef MEM_WSTRB_EN
    localparam int unsigned LANES = WORDS_PER_LINE * (WIDTH / 8);
`else
    localparam int unsigned LANES = WORDS_PER_LINE;
`endif
    localparam int unsigned LANES_PER_WORD = LANES / WORDS_PER_LINE;
    localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    mem_state_t           r_state;
    logic [3:0]           r_cnt;
    logic                 r_ready;
    logic                 r_ack;
    logic                 r_we;
    logic [LINE_BITS-1:0] r_idx;
    logic [1:0]           r_wsel;
    logic [WIDTH-1:0]     r_wdata;
`ifdef MEM_WSTRB_EN
    logic [3:0]           r_wstrb;
`endif

    logic                      w_accept;
    logic [LINE_BITS-1:0]      w_in_idx;
    logic [LINE_BITS-1:0]      w_ram_addr;
    logic                      w_ram_re;
    logic [LANES-1:0]          w_lane_we;
    logic [DATA_WIDTH_MEM-1:0] w_ram_wdata;
    logic                      w_unused_addr;

    assign w_accept      = bus.mem_req && r_ready;
    assign w_in_idx      = bus.mem_addr[LINE_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign w_unused_addr = ^{bus.mem_addr[WIDTH-1:LINE_BITS+OFFSET_BITS], bus.mem_addr[1:0]};

    // The line is fetched on the edge that enters RESP so the registered RAM
    // output doubles as mem_rdata; with LATENCY=1 that edge is the accept edge.
    assign w_ram_addr = (r_state == IDLE) ? w_in_idx : r_idx;
    assign w_ram_re   = ((r_state == IDLE) && w_accept && !bus.mem_we && (LATENCY == 1))
                     || ((r_state == WAIT) && (r_cnt == '0) && !r_we);
    assign w_ram_wdata = {WORDS_PER_LINE{r_wdata}};

    always_comb begin
        w_lane_we = '0;
        if ((r_state == RESP) && r_we) begin
            for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
                for (int unsigned b = 0; b < LANES_PER_WORD; b++) begin
`ifdef MEM_WSTRB_EN
                    w_lane_we[w*LANES_PER_WORD + b] = (r_wsel == 2'(w)) && r_wstrb[b];
`else
                    w_lane_we[w*LANES_PER_WORD + b] = (r_wsel == 2'(w));
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_ack   <= 1'b0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wsel  <= '0;
            r_wdata <= '0;
`ifdef MEM_WSTRB_EN
            r_wstrb <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we    <= bus.mem_we;
                        r_idx   <= w_in_idx;
                        r_wsel  <= bus.mem_addr[OFFSET_BITS-1:2];
                        r_wdata <= bus.mem_wdata;
`ifdef MEM_WSTRB_EN
                        r_wstrb <= bus.mem_wstrb;
`endif
                        r_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.mem_ready = r_ready;
    assign bus.mem_ack   = r_ack;

    mem_line_ram #(
        .MEM_DEPTH      (MEM_DEPTH),
        .DATA_WIDTH_MEM (DATA_WIDTH_MEM),
        .LANES          (LANES),
        .ADDR_BITS      (LINE_BITS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (w_ram_addr),
        .i_we    (w_lane_we),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .o_rdata (bus.mem_rdata)
    );

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Memory-side responder for the data cache refill/update path. Accepts single-outstanding word-write and line-read requests from the cache controller, models a fixed access latency, and returns full 128-bit cache lines on the `data_mem`-style refill bus. It sits between the cache controller/data array and the (simulated or on-chip) backing store, and is the transmitting end of the refill interface.

## Interface
- `WIDTH`, 32, CPU address/word width
- `DATA_WIDTH_MEM`, 128, line width; fixed at 4 words of `WIDTH`
- `MEM_DEPTH`, 256, number of lines in the backing store; power of two
- `LATENCY`, 4, cycles from request acceptance to `mem_ack`; legal range 1..15

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `mem_req`  in  1  request valid
- `mem_we`  in  1  1 = word write, 0 = line read
- `mem_addr`  in  `WIDTH`  byte address
- `mem_wdata`  in  `WIDTH`  write word
- `mem_ready`  out  1  responder idle, can accept
- `mem_ack`  out  1  one-cycle completion pulse (read or write)
- `mem_rdata`  out  `DATA_WIDTH_MEM`  read line, valid when `mem_ack` is high for a read

## Operation
- Address split: offset = `mem_addr[3:0]`, word select = `mem_addr[3:2]`, line index = `mem_addr[LINE_BITS+3:4]`. Upper bits are ignored, so addresses alias modulo `MEM_DEPTH` lines.
- A request is accepted on a rising edge where `mem_req && mem_ready`. At acceptance, `mem_we`, the index, the word select and `mem_wdata` are captured. Inputs are don't-care afterwards.
- FSM states:
  - IDLE: `mem_ready`=1. On accept, go to WAIT with the counter loaded, or go directly to RESP when `LATENCY`=1.
  - WAIT: decrement the counter; at terminal count go to RESP.
  - RESP: `mem_ack`=1 for exactly one cycle. A read drives the captured line onto `mem_rdata`. A write updates word [word select] of the captured line. Then go to IDLE.
- `mem_req` while not ready is ignored. The requester holds the request until it sees `mem_ready`.
- `mem_rdata` is registered and holds the last read line until the next read ack. Write acks do not change it.
- Write lane order matches the data array: word k occupies bits [32k+31:32k].
- Store contents are not reset; they power up as X in simulation.

## Timing
- Reset values: `mem_ready`=1, `mem_ack`=0, `mem_rdata`=0, FSM=IDLE, counter=0.
- If the request is accepted at edge T, `mem_ack` is high in the cycle after edge T+`LATENCY`−1. Throughput is one request per `LATENCY`+1 cycles.
- `mem_ready` drops in the cycle after the accept edge and returns with the cycle after the ack.
- A write commits on the edge that ends the ack cycle. A read accepted afterwards to the same line returns the new word.
- Reset asserted mid-operation aborts immediately: the pending write is discarded, no ack is issued, and the FSM returns to IDLE.

## Configuration
- `MEM_WSTRB_EN` defined: adds input port `mem_wstrb` [3:0], captured at accept. Only byte lanes with a strobe set are written. Strobe 4'b0000 still acks but changes nothing.
- `MEM_WSTRB_EN` undefined: no `mem_wstrb` port, and every write replaces the full 32-bit word.

## Structure
- Package `mem_pkg` holds:
  - state enum `mem_state_t` {IDLE, WAIT, RESP}
  - localparams `OFFSET_BITS`=4, `WORDS_PER_LINE`=4
  - function `line_bits(depth)` = $clog2(depth)
- One sub-module, `mem_line_ram`: a synchronous single-port line RAM, `MEM_DEPTH` × `DATA_WIDTH_MEM`, with per-word write enable and registered read. The responder owns the FSM, counter, capture registers and strobe merge.

## Test plan
- Reset release: `mem_ready`=1, `mem_ack`=0, `mem_rdata`=0.
- Write 0xDEADBEEF to 0x0000_0024, then read 0x0000_0020 → ack after 4 cycles each. Read line has word1=0xDEADBEEF.
- Back-to-back requests held with `mem_req`=1: the second request is accepted only on the cycle after the first ack, with no lost or duplicated ack.
- Aliasing: write to address 0x0000_1000+0x10 with `MEM_DEPTH`=256, then read 0x0000_0010 → same line returned.
- Reset asserted during WAIT of a write to 0x30 → no ack. A later read of 0x30 shows the old contents.
- `MEM_WSTRB_EN`: write 0x11223344 with strb 4'b0101 over 0xAAAAAAAA → word reads 0xAA22AA44.
